// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential multiplier.
//   state_e    : controller states
//   num_digits : digits per operand (WIDTH / CHUNK)
//   idx_width  : width of a digit index, at least one bit
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_e;

   function automatic int unsigned num_digits(input int unsigned width,
                                              input int unsigned chunk);
      return width / chunk;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_seq_fsm.sv
// Controller for mult_seq: state register, digit indices, busy/done flags.
// Ports:
//   clk, reset           : clock, async active-low reset
//   start                : request, honoured only in IDLE
//   busy, done           : registered status (done is a one-cycle pulse)
//   capture_c, clr_prod_c: load operands / clear accumulator (IDLE + start)
//   upd_prod_c           : accumulate one partial product (CALC)
//   negate_c             : conditional negation slot (FIX)
//   i, j                 : current multiplicand / multiplier digit indices
module mult_seq_fsm
   import mult_pkg::*;
#(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          capture_c,
   output logic          clr_prod_c,
   output logic          upd_prod_c,
   output logic          negate_c,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j
);

   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_e        state, state_d;
   logic [IW-1:0] i_d, j_d;
   logic          busy_d, done_d;

   // State, index and status registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         i     <= '0;
         j     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         i     <= i_d;
         j     <= j_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   // Next state, next indices and datapath controls
   always_comb begin
      state_d    = state;
      i_d        = i;
      j_d        = j;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      capture_c  = 1'b0;
      clr_prod_c = 1'b0;
      upd_prod_c = 1'b0;
      negate_c   = 1'b0;

      unique case (state)
         IDLE: begin
            if (start) begin
               capture_c  = 1'b1;
               clr_prod_c = 1'b1;
               i_d        = '0;
               j_d        = '0;
               busy_d     = 1'b1;
               state_d    = CALC;
            end
         end
         CALC: begin
            upd_prod_c = 1'b1;
            busy_d     = 1'b1;
            // j is the inner digit loop; i advances when j wraps
            if (j == LAST) begin
               j_d = '0;
               if (i == LAST) begin
                  i_d     = '0;
                  state_d = FIX;
               end else begin
                  i_d = i + IW'(1);
               end
            end else begin
               j_d = j + IW'(1);
            end
         end
         FIX: begin
            negate_c = 1'b1;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: rtl/mult_seq.sv
// Parametrised sequential multiplier (unsigned or two's-complement).
// Operand magnitudes are captured on start, CHUNK x CHUNK digit products are
// accumulated one per clock, and the sign is applied in a final FIX cycle.
// Ports:
//   clk, reset         : clock, async active-low reset
//   start              : request, sampled only when idle
//   signed_mode        : 1 = two's-complement operands (captured with start)
//   a, b               : WIDTH-bit operands (captured with start)
//   busy               : computation in progress
//   done               : one-cycle pulse when product is final
//   product            : 2*WIDTH-bit result register
module mult_seq
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned N  = num_digits(WIDTH, CHUNK);
   localparam int unsigned IW = idx_width(N);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned DW = 2 * CHUNK;
   localparam int unsigned SW = $clog2(PW) + 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("mult_seq: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   logic          capture_c, clr_prod_c, upd_prod_c, negate_c;
   logic [IW-1:0] i, j;

   mult_seq_fsm #(
      .N  (N),
      .IW (IW)
   ) u_fsm (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .capture_c  (capture_c),
      .clr_prod_c (clr_prod_c),
      .upd_prod_c (upd_prod_c),
      .negate_c   (negate_c),
      .i          (i),
      .j          (j)
   );

   logic [WIDTH-1:0] amag, bmag;
   logic             neg;
   logic             a_neg_c, b_neg_c;

   assign a_neg_c = signed_mode & a[WIDTH-1];
   assign b_neg_c = signed_mode & b[WIDTH-1];

   // Operand magnitude capture; -2^(WIDTH-1) negates to itself, which is
   // exactly its unsigned magnitude
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         amag <= '0;
         bmag <= '0;
         neg  <= 1'b0;
      end else if (capture_c) begin
         amag <= a_neg_c ? (~a + WIDTH'(1)) : a;
         bmag <= b_neg_c ? (~b + WIDTH'(1)) : b;
         neg  <= a_neg_c ^ b_neg_c;
      end
   end

   logic [CHUNK-1:0] a_dig_c, b_dig_c;
   logic [DW-1:0]    pp_c;
   logic [SW-1:0]    shamt_c;
   logic [PW-1:0]    pp_shift_c;

   // Digit selection by index compare keeps every slice in range
   always_comb begin
      a_dig_c = '0;
      b_dig_c = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (i == IW'(k)) a_dig_c = amag[k*CHUNK +: CHUNK];
         if (j == IW'(k)) b_dig_c = bmag[k*CHUNK +: CHUNK];
      end
   end

   // Partial product aligned to digit position i+j
   assign pp_c       = DW'(a_dig_c) * DW'(b_dig_c);
   assign shamt_c    = SW'(CHUNK) * (SW'(i) + SW'(j));
   assign pp_shift_c = PW'(pp_c) << shamt_c;

   // Accumulator
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         product <= '0;
      end else if (clr_prod_c) begin
         product <= '0;
      end else if (upd_prod_c) begin
         product <= product + pp_shift_c;
      end else if (negate_c && neg) begin
         product <= ~product + PW'(1);
      end
   end

endmodule
